// File: rtl/serial_cmd_executor.sv
// rtl/serial_cmd_executor.sv - framed serial command parser, register bank and response sequencer
// Frames in both directions: FF FF 00 LEN PAYLOAD[LEN] EE EE.
module serial_cmd_executor #(
    parameter int REG_COUNT    = 8,
    parameter int MAX_PAYLOAD  = 8,
    parameter int BYTE_TIMEOUT = 4340
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_err,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   rx_drop,
    output logic [REG_COUNT*8-1:0] reg_file
);
    localparam int IDX_W  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int PIDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int CNT_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int TMR_W  = $clog2(BYTE_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_HUNT, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_EOF1, S_EOF2, S_EXEC, S_RESP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_regs [REG_COUNT];
    logic [7:0]       r_payload [MAX_PAYLOAD];
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_resp_cmd;
    logic [7:0]       r_resp_status;
    logic [7:0]       r_resp_idx;
    logic [7:0]       r_resp_val;
    logic [3:0]       r_tx_cnt;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_rx_drop;

    logic             w_busy;
    logic             w_timeout;
    logic             w_rx_byte;
    logic             w_len_ok;
    logic             w_len_load;
    logic             w_pay_store;
    logic             w_tx_fire;
    logic             w_tx_last;
    logic             w_known;
    logic             w_len_match;
    logic             w_idx_ok;
    logic [7:0]       w_cmd;
    logic [7:0]       w_idx;
    logic [IDX_W-1:0] w_idx_sel;
    logic [7:0]       w_status;
    logic [7:0]       w_value;
    logic [7:0]       w_next_byte;

    assign w_busy    = (r_state == S_EXEC) || (r_state == S_RESP);
    assign w_timeout = (r_timer >= TMR_W'(BYTE_TIMEOUT));
    assign w_rx_byte = rx_valid && !rx_err && !w_busy;
    assign w_len_ok  = (rx_data != 8'h00) && (32'(rx_data) <= 32'(MAX_PAYLOAD));
    assign w_tx_fire = r_tx_valid && tx_ready;
    assign w_tx_last = (r_tx_cnt == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_load  = 1'b0;
        w_pay_store = 1'b0;
        case (r_state)
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: if (w_tx_fire && w_tx_last) w_state_nxt = S_HUNT;
            S_HUNT: if (w_rx_byte && rx_data == 8'hFF) w_state_nxt = S_SOF2;
            default: begin
                // A line error or a stalled sender throws the partial frame away.
                if (rx_err || w_timeout) begin
                    w_state_nxt = S_HUNT;
                end else if (rx_valid) begin
                    w_state_nxt = S_HUNT;
                    case (r_state)
                        S_SOF2:  if (rx_data == 8'hFF) w_state_nxt = S_SPACE;
                        S_SPACE: if (rx_data == 8'h00) w_state_nxt = S_LEN;
                        S_LEN: begin
                            if (w_len_ok) begin
                                w_state_nxt = S_PAYLOAD;
                                w_len_load  = 1'b1;
                            end
                        end
                        S_PAYLOAD: begin
                            w_pay_store = 1'b1;
                            w_state_nxt = (r_cnt == r_len - CNT_W'(1)) ? S_EOF1 : S_PAYLOAD;
                        end
                        S_EOF1:  if (rx_data == 8'hEE) w_state_nxt = S_EOF2;
                        S_EOF2:  if (rx_data == 8'hEE) w_state_nxt = S_EXEC;
                        default: w_state_nxt = S_HUNT;
                    endcase
                end
            end
        endcase
    end

    assign w_cmd       = r_payload[0];
    assign w_idx       = r_payload[1];
    assign w_idx_sel   = w_idx[IDX_W-1:0];
    assign w_known     = (w_cmd == 8'h01) || (w_cmd == 8'h02);
    assign w_len_match = ((w_cmd == 8'h01) && (r_len == CNT_W'(3))) ||
                         ((w_cmd == 8'h02) && (r_len == CNT_W'(2)));
    assign w_idx_ok    = (32'(w_idx) < 32'(REG_COUNT));

    always_comb begin
        w_status = 8'h00;
        if (!w_known) begin
            w_status = 8'h01;
        end else if (!w_len_match) begin
            w_status = 8'h03;
        end else if (!w_idx_ok) begin
            w_status = 8'h02;
        end
    end

    assign w_value = (w_status != 8'h00) ? 8'h00 :
                     (w_cmd == 8'h01)    ? r_payload[2] : r_regs[w_idx_sel];

    // Byte that follows the one currently presented, indexed by r_tx_cnt.
    always_comb begin
        w_next_byte = 8'h00;
        case (r_tx_cnt)
            4'd0:    w_next_byte = 8'hFF;
            4'd1:    w_next_byte = 8'h00;
            4'd2:    w_next_byte = 8'h04;
            4'd3:    w_next_byte = r_resp_cmd;
            4'd4:    w_next_byte = r_resp_status;
            4'd5:    w_next_byte = r_resp_idx;
            4'd6:    w_next_byte = r_resp_val;
            4'd7:    w_next_byte = 8'hEE;
            4'd8:    w_next_byte = 8'hEE;
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 8'h00;
            for (int i = 0; i < MAX_PAYLOAD; i++) r_payload[i] <= 8'h00;
            r_len         <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_resp_cmd    <= 8'h00;
            r_resp_status <= 8'h00;
            r_resp_idx    <= 8'h00;
            r_resp_val    <= 8'h00;
            r_tx_cnt      <= 4'd0;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_rx_drop     <= 1'b0;
        end else begin
            r_rx_drop <= w_busy && rx_valid;

            if (rx_valid) begin
                r_timer <= '0;
            end else if (!w_timeout) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_len_load) begin
                r_len <= rx_data[CNT_W-1:0];
                r_cnt <= '0;
            end
            if (w_pay_store) begin
                r_payload[r_cnt[PIDX_W-1:0]] <= rx_data;
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == S_EXEC) begin
                if (w_status == 8'h00 && w_cmd == 8'h01) begin
                    r_regs[w_idx_sel] <= r_payload[2];
                end
                r_resp_cmd    <= w_cmd;
                r_resp_status <= w_status;
                r_resp_idx    <= w_idx;
                r_resp_val    <= w_value;
                r_tx_cnt      <= 4'd0;
                r_tx_data     <= 8'hFF;
                r_tx_valid    <= 1'b1;
            end else if (r_state == S_RESP && w_tx_fire) begin
                if (w_tx_last) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_tx_cnt  <= r_tx_cnt + 4'd1;
                    r_tx_data <= w_next_byte;
                end
            end
        end
    end

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg_out
        assign reg_file[gi*8 +: 8] = r_regs[gi];
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = w_busy;
    assign rx_drop  = r_rx_drop;

endmodule

// File: tb/tb_serial_cmd_executor.sv
// tb/tb_serial_cmd_executor.sv - randomized self-checking bench for serial_cmd_executor
`timescale 1ns/1ps
module tb_serial_cmd_executor;
    localparam int REG_COUNT = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [7:0]             rx_data = 8'h00;
    logic                   rx_valid = 1'b0;
    logic                   rx_err = 1'b0;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready = 1'b0;
    logic                   busy;
    logic                   rx_drop;
    logic [REG_COUNT*8-1:0] reg_file;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] byte_q[$];
    logic       err_q[$];
    logic [7:0] m_regs[REG_COUNT];
    int         drop_cnt = 0;
    int         ready_mode = 1;
    int         stall_cnt = 0;
    bit         ex_ok;
    logic       ex_busy_last, ex_busy_after, ex_valid_after;

    serial_cmd_executor #(.REG_COUNT(REG_COUNT), .MAX_PAYLOAD(8), .BYTE_TIMEOUT(4340)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .rx_drop(rx_drop), .reg_file(reg_file)
    );

    always #10 clk = ~clk;

    // Transmitter side: choose tx_ready for the coming edge, then log any transfer it completes.
    always @(negedge clk) begin
        case (ready_mode)
            0: tx_ready = ($urandom_range(0, 1) == 1);
            1: tx_ready = 1'b1;
            default: begin
                if (got_q.size() == 3 && stall_cnt < 300) begin
                    tx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        endcase
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (rx_drop) drop_cnt++;
    end

    function automatic logic [79:0] model_frame(input logic [7:0] len, input logic [7:0] p0,
                                                input logic [7:0] p1, input logic [7:0] p2);
        logic [7:0] st;
        logic [7:0] val;
        if (p0 != 8'h01 && p0 != 8'h02) st = 8'h01;
        else if ((p0 == 8'h01 && len != 8'd3) || (p0 == 8'h02 && len != 8'd2)) st = 8'h03;
        else if (p1 >= 8'(REG_COUNT)) st = 8'h02;
        else st = 8'h00;
        val = 8'h00;
        if (st == 8'h00) begin
            if (p0 == 8'h01) begin
                m_regs[int'(p1)] = p2;
                val = p2;
            end else begin
                val = m_regs[int'(p1)];
            end
        end
        return {8'hFF, 8'hFF, 8'h00, 8'h04, p0, st, p1, val, 8'hEE, 8'hEE};
    endfunction

    function automatic logic [REG_COUNT*8-1:0] model_file();
        logic [REG_COUNT*8-1:0] v;
        for (int i = 0; i < REG_COUNT; i++) v[i*8 +: 8] = m_regs[i];
        return v;
    endfunction

    function automatic logic [79:0] got_vec();
        logic [79:0] v = '0;
        for (int i = 0; i < got_q.size() && i < 10; i++) v = {v[71:0], got_q[i]};
        return v;
    endfunction

    task automatic build_frame(input logic [7:0] len, input logic [7:0] p0,
                               input logic [7:0] p1, input logic [7:0] p2);
        byte_q.delete();
        err_q.delete();
        byte_q = '{8'hFF, 8'hFF, 8'h00, len};
        for (int i = 0; i < int'(len); i++)
            byte_q.push_back(i == 0 ? p0 : i == 1 ? p1 : i == 2 ? p2 : 8'($urandom));
        byte_q.push_back(8'hEE);
        byte_q.push_back(8'hEE);
        foreach (byte_q[i]) err_q.push_back(1'b0);
    endtask

    task automatic send_q(input int maxgap);
        for (int i = 0; i < byte_q.size(); i++) begin
            @(negedge clk);
            rx_data  = byte_q[i];
            rx_valid = 1'b1;
            rx_err   = (i < err_q.size()) ? err_q[i] : 1'b0;
            @(negedge clk);
            rx_valid = 1'b0;
            rx_err   = 1'b0;
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
    endtask

    task automatic exchange(input int maxgap);
        got_q.delete();
        send_q(maxgap);
        ex_ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (got_q.size() >= 10) begin
                ex_ok = 1'b1;
                break;
            end
        end
        ex_busy_last = busy;
        @(negedge clk); #1;
        ex_busy_after  = busy;
        ex_valid_after = tx_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rx_drop !== 1'b0) begin errors++; $display("FAIL reset_rx_drop got %b want 0", rx_drop); end
        checks++; if (reg_file !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", reg_file); end
    endtask

    task automatic test_read_reset();
        logic [79:0] exp;
        ready_mode = 1;
        build_frame(8'd2, 8'h02, 8'h03, 8'h00);
        exp = model_frame(8'd2, 8'h02, 8'h03, 8'h00);
        exchange(3);
        checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL read3_resp got %h (%0d bytes) want %h", got_vec(), got_q.size(), exp); end
        checks++; if (ex_busy_last !== 1'b1) begin errors++; $display("FAIL read3_busy_at_last got %b want 1", ex_busy_last); end
        checks++; if (ex_busy_after !== 1'b0) begin errors++; $display("FAIL read3_busy_after got %b want 0", ex_busy_after); end
        checks++; if (ex_valid_after !== 1'b0) begin errors++; $display("FAIL read3_valid_after got %b want 0", ex_valid_after); end
    endtask

    task automatic test_write_read();
        logic [79:0] exp;
        ready_mode = 0;
        build_frame(8'd3, 8'h01, 8'h05, 8'hA5);
        exp = model_frame(8'd3, 8'h01, 8'h05, 8'hA5);
        exchange(4);
        checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL write5_resp got %h want %h", got_vec(), exp); end
        build_frame(8'd2, 8'h02, 8'h05, 8'h00);
        exp = model_frame(8'd2, 8'h02, 8'h05, 8'h00);
        exchange(4);
        checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL read5_resp got %h want %h", got_vec(), exp); end
        checks++; if (reg_file[47:40] !== 8'hA5) begin errors++; $display("FAIL reg5_value got %h want a5", reg_file[47:40]); end
    endtask

    task automatic test_errors();
        logic [79:0] exp;
        logic [7:0]  lens [3] = '{8'd2, 8'd2, 8'd2};
        logic [7:0]  cmds [3] = '{8'h07, 8'h02, 8'h01};
        logic [7:0]  idxs [3] = '{8'h01, 8'h09, 8'h02};
        ready_mode = 0;
        for (int k = 0; k < 3; k++) begin
            build_frame(lens[k], cmds[k], idxs[k], 8'h00);
            exp = model_frame(lens[k], cmds[k], idxs[k], 8'h00);
            exchange(2);
            checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL err_status_%0d got %h want %h", k, got_vec(), exp); end
            checks++; if (reg_file !== model_file()) begin errors++; $display("FAIL err_regs_%0d got %h want %h", k, reg_file, model_file()); end
        end
    endtask

    task automatic test_aborts();
        logic [79:0] exp;
        ready_mode = 1;
        for (int k = 0; k < 4; k++) begin
            got_q.delete();
            build_frame(8'd2, 8'h02, 8'h03, 8'h00);
            case (k)
                0: err_q[3] = 1'b1;
                1: byte_q[6] = 8'hEF;
                2: begin
                    byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hEE, 8'hEE};
                    err_q  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                end
                default: begin
                    byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02};
                    err_q  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                    send_q(1);
                    repeat (5000) @(negedge clk);
                    byte_q = '{8'h03, 8'hEE, 8'hEE};
                    err_q  = '{1'b0, 1'b0, 1'b0};
                end
            endcase
            send_q(1);
            repeat (40) @(negedge clk);
            #1;
            checks++; if (got_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_%0d_quiet got %0d bytes busy %b want 0 bytes busy 0", k, got_q.size(), busy); end
            build_frame(8'd2, 8'h02, 8'h05, 8'h00);
            exp = model_frame(8'd2, 8'h02, 8'h05, 8'h00);
            exchange(2);
            checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL abort_%0d_recover got %h want %h", k, got_vec(), exp); end
        end
    endtask

    task automatic test_stall();
        logic [79:0] exp;
        int          drops0;
        bit          seen;
        ready_mode = 3;
        stall_cnt  = 0;
        got_q.delete();
        build_frame(8'd2, 8'h02, 8'h05, 8'h00);
        exp = model_frame(8'd2, 8'h02, 8'h05, 8'h00);
        send_q(2);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk); #1;
            seen = (got_q.size() == 3);
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_reach_byte4 got %0d bytes want 3", got_q.size()); end
        @(negedge clk); #1;
        for (int c = 0; c < 250; c++) begin
            checks++;
            if (tx_data !== 8'h04 || tx_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got data %h valid %b want 04 1", c, tx_data, tx_valid);
                break;
            end
            @(negedge clk); #1;
        end
        drops0 = drop_cnt;
        byte_q = '{8'h55};
        err_q  = '{1'b0};
        send_q(0);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (drop_cnt - drops0 != 1) begin errors++; $display("FAIL rx_drop_pulses got %0d want 1", drop_cnt - drops0); end
        for (int c = 0; c < 400 && got_q.size() < 10; c++) @(negedge clk);
        @(negedge clk); #1;
        checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL stall_resp got %h want %h", got_vec(), exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end got %b want 0", busy); end
        ready_mode = 1;
    endtask

    task automatic test_random();
        logic [79:0] exp;
        logic [7:0]  cmd, idx, len, wv;
        int          r;
        ready_mode = 0;
        for (int n = 0; n < 24; n++) begin
            r   = $urandom_range(0, 9);
            cmd = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
            idx = 8'($urandom_range(0, 11));
            wv  = 8'($urandom);
            if ($urandom_range(0, 4) == 0 || (cmd != 8'h01 && cmd != 8'h02)) len = 8'($urandom_range(2, 8));
            else len = (cmd == 8'h01) ? 8'd3 : 8'd2;
            build_frame(len, cmd, idx, wv);
            exp = model_frame(len, cmd, idx, wv);
            exchange(6);
            checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL random_%0d got %h want %h", n, got_vec(), exp); end
        end
        checks++; if (reg_file !== model_file()) begin errors++; $display("FAIL random_regs got %h want %h", reg_file, model_file()); end
    endtask

    task automatic test_back_to_back();
        logic [79:0] exp;
        ready_mode = 1;
        for (int n = 0; n < 3; n++) begin
            build_frame(8'd3, 8'h01, 8'(n), 8'(8'h30 + n));
            exp = model_frame(8'd3, 8'h01, 8'(n), 8'(8'h30 + n));
            exchange(0);
            checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL b2b_%0d got %h want %h", n, got_vec(), exp); end
        end
    endtask

    task automatic test_reset_mid_resp();
        logic [79:0] exp;
        bit          seen;
        ready_mode = 1;
        build_frame(8'd3, 8'h01, 8'h00, 8'h5A);
        exp = model_frame(8'd3, 8'h01, 8'h00, 8'h5A);
        exchange(1);
        checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL prerst_write got %h want %h", got_vec(), exp); end
        got_q.delete();
        build_frame(8'd2, 8'h02, 8'h00, 8'h00);
        send_q(0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk); #1;
            seen = (got_q.size() == 3);
        end
        rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got valid %b busy %b want 0 0", tx_valid, busy); end
        checks++; if (reg_file !== '0) begin errors++; $display("FAIL rst_regs got %h want 0", reg_file); end
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++; if (got_q.size() != 3 || tx_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resume got %0d bytes valid %b want 3 0", got_q.size(), tx_valid); end
        build_frame(8'd2, 8'h02, 8'h00, 8'h00);
        exp = model_frame(8'd2, 8'h02, 8'h00, 8'h00);
        exchange(1);
        checks++; if (got_q.size() != 10 || got_vec() !== exp) begin errors++; $display("FAIL postrst_read got %h want %h", got_vec(), exp); end
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        test_reset();
        test_read_reset();
        test_write_read();
        test_errors();
        test_aborts();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
